moving_average_filter: RTL and testbench

- Parametrised N-tap boxcar (moving-average) filter on a signed sample stream qualified by a clock-enable.
- Successor to the 2-tap averager in the DSP filter library; adds configurable power-of-two tap count, a running-sum architecture, a selectable rounding mode, a synchronous history clear and a history-full flag.
- Sits between a CE-strobed sample source (ADC front end, decimator) and downstream filter stages; it keeps the same 2-cycle CE-pipelined output contract as the existing library filters.

---
 rtl/moving_average_pkg.sv | 25 ++
 rtl/avg_history_buffer.sv | 56 +++++
 rtl/moving_average_filter.sv | 118 +++++++++++
 tb/tb_moving_average_filter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/moving_average_pkg.sv
// Shared definitions for the moving-average filter family.
//
// Contents:
//   ROUND_TRUNC / ROUND_HALF_UP : rounding-mode selectors for ROUND_MODE
//   acc_width()                 : running-sum width that cannot overflow
//   round_const()               : bias added before the divide-by-TAPS shift
package moving_average_pkg;

  localparam int ROUND_TRUNC   = 0;
  localparam int ROUND_HALF_UP = 1;

  // The sum of 2**log2_taps samples needs log2_taps extra bits.
  function automatic int acc_width(input int data_width, input int log2_taps);
    return data_width + log2_taps;
  endfunction

  // Half an LSB of the shifted result gives round-half-up; zero gives floor.
  function automatic int round_const(input int mode, input int log2_taps);
    if (mode == ROUND_HALF_UP) begin
      return 1 << (log2_taps - 1);
    end
    return 0;
  endfunction

endpackage

// File: rtl/avg_history_buffer.sv
// Circular history buffer holding the last TAPS samples of the filter window.
//
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   wr_en        : store wr_data at the pointer and advance it
//   clear        : flush history, pointer and fill count (wins over wr_en)
//   wr_data      : sample to store
//   oldest       : entry at the pointer, i.e. the sample leaving the window
//   wrap         : the pointer sits on the last entry; the next write wraps
//   full         : TAPS samples stored since reset or clear
module avg_history_buffer
  import moving_average_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LOG2_TAPS  = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr_en,
  input  logic                         clear,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  output logic signed [DATA_WIDTH-1:0] oldest,
  output logic                         wrap,
  output logic                         full
);

  localparam int TAPS = 1 << LOG2_TAPS;
  localparam logic [LOG2_TAPS-1:0] PTR_LAST = LOG2_TAPS'(TAPS - 1);
  localparam logic [LOG2_TAPS:0]   FILL_MAX = (LOG2_TAPS + 1)'(TAPS);

  logic signed [DATA_WIDTH-1:0] hist [TAPS];
  logic [LOG2_TAPS-1:0]         ptr;
  logic [LOG2_TAPS:0]           fill;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      for (int i = 0; i < TAPS; i++) begin
        hist[i] <= '0;
      end
      ptr  <= '0;
      fill <= '0;
    end else if (wr_en) begin
      hist[ptr] <= wr_data;
      // TAPS is a power of two, so the natural wrap of ptr is the ring wrap.
      ptr <= ptr + 1'b1;
      if (fill != FILL_MAX) begin
        fill <= fill + 1'b1;
      end
    end
  end

  assign oldest = hist[ptr];
  assign wrap   = (ptr == PTR_LAST);
  assign full   = (fill == FILL_MAX);

endmodule

// File: rtl/moving_average_filter.sv
// N-tap boxcar (moving-average) filter on a CE-qualified signed stream.
//
// Stage 0 keeps a running sum: each accepted sample adds itself and
// subtracts the sample it evicts from the circular history. Stage 1 divides
// the sum by TAPS with an arithmetic shift (optionally rounded half up).
//
// Strobe contract: data_in is taken on any cycle with i_ce=1 and i_clear=0;
// there is no back-pressure. The matching result appears two cycles later
// with o_ce high for exactly one cycle, and data_out holds between strobes.
// i_clear drops a coincident sample but never cancels a result already in
// stage 1.
//
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   i_ce         : input sample strobe
//   i_clear      : synchronous history flush (single-cycle pulse)
//   data_in      : signed input sample
//   data_out     : signed averaged sample
//   o_ce         : data_out updated this cycle
//   o_full       : TAPS samples accepted since reset or clear
module moving_average_filter
  import moving_average_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LOG2_TAPS  = 2,
  parameter int ROUND_MODE = ROUND_TRUNC
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_ce,
  input  logic                         i_clear,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         o_ce,
  output logic                         o_full
);

  localparam int ACC_W = acc_width(DATA_WIDTH, LOG2_TAPS);
  localparam logic signed [ACC_W-1:0] RND =
    ACC_W'(round_const(ROUND_MODE, LOG2_TAPS));

  logic                         wr_en;
  logic signed [DATA_WIDTH-1:0] oldest;
  logic                         hist_wrap;
  logic                         hist_full;
  logic signed [ACC_W-1:0]      din_ext;
  logic signed [ACC_W-1:0]      old_ext;
  logic signed [ACC_W-1:0]      acc;
  logic                         s1_ce;
  logic                         wrapped;

  assign wr_en = i_ce & ~i_clear;

  avg_history_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .LOG2_TAPS (LOG2_TAPS)
  ) u_hist (
    .clk    (clk),
    .reset_n(reset_n),
    .wr_en  (wr_en),
    .clear  (i_clear),
    .wr_data(data_in),
    .oldest (oldest),
    .wrap   (hist_wrap),
    .full   (hist_full)
  );

  assign din_ext = {{LOG2_TAPS{data_in[DATA_WIDTH-1]}}, data_in};
  assign old_ext = {{LOG2_TAPS{oldest[DATA_WIDTH-1]}}, oldest};

  // Stage 0: running sum and stage-1 strobe.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc   <= '0;
      s1_ce <= 1'b0;
    end else begin
      s1_ce <= wr_en;
      if (i_clear) begin
        acc <= '0;
      end else if (i_ce) begin
        acc <= acc + din_ext - old_ext;
      end
    end
  end

  // Stage 1: divide by TAPS. |acc + RND| stays below TAPS * 2**(DATA_WIDTH-1),
  // so the shifted value always fits DATA_WIDTH and needs no saturation.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out <= '0;
      o_ce     <= 1'b0;
    end else begin
      o_ce <= s1_ce;
      if (s1_ce) begin
        data_out <= DATA_WIDTH'((acc + RND) >>> LOG2_TAPS);
      end
    end
  end

  assign o_full = hist_full;

  // The first pointer wrap after reset or clear is the TAPS-th write, so a
  // sticky wrap flag must agree with the buffer's fill-count based flag.
  always_ff @(posedge clk) begin
    if (!reset_n || i_clear) begin
      wrapped <= 1'b0;
    end else if (wr_en && hist_wrap) begin
      wrapped <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (wrapped == hist_full);
    end
  end

endmodule

// File: tb/tb_moving_average_filter.sv
// Bench for moving_average_filter: a truncating and a round-half-up instance
// share one input stream; expected results are queued when a sample is
// driven and compared when o_ce appears.
module tb_moving_average_filter;

  logic              clk;
  logic              reset_n;
  logic              i_ce;
  logic              i_clear;
  logic signed [7:0] data_in;
  logic signed [7:0] data_out_t;
  logic              o_ce_t;
  logic              o_full_t;
  logic signed [7:0] data_out_r;
  logic              o_ce_r;
  logic              o_full_r;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // {expected o_ce cycle[31:16], trunc result[15:8], round result[7:0]}
  logic [31:0] exp_q[$];

  typedef struct {
    logic              ce;
    logic              clr;
    logic signed [7:0] din;
    int                gap;
    logic signed [7:0] exp_t;
    logic signed [7:0] exp_r;
    logic              exp_full;
  } vec_t;

  vec_t vecs[$];

  moving_average_filter #(.DATA_WIDTH(8), .LOG2_TAPS(2), .ROUND_MODE(0)) dut_t (
    .clk(clk), .reset_n(reset_n), .i_ce(i_ce), .i_clear(i_clear),
    .data_in(data_in), .data_out(data_out_t), .o_ce(o_ce_t), .o_full(o_full_t)
  );

  moving_average_filter #(.DATA_WIDTH(8), .LOG2_TAPS(2), .ROUND_MODE(1)) dut_r (
    .clk(clk), .reset_n(reset_n), .i_ce(i_ce), .i_clear(i_clear),
    .data_in(data_in), .data_out(data_out_r), .o_ce(o_ce_r), .o_full(o_full_r)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired actual running required finished");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic add_v(input logic ce, input logic clr, input int din, input int gap,
                       input int et, input int er, input logic ef);
    vec_t v;
    v.ce = ce; v.clr = clr; v.din = 8'(din); v.gap = gap;
    v.exp_t = 8'(et); v.exp_r = 8'(er); v.exp_full = ef;
    vecs.push_back(v);
  endtask

  // Drive one cycle of stimulus, queue its result, then idle for gap cycles.
  task automatic drive(input vec_t v);
    i_ce    = v.ce;
    i_clear = v.clr;
    data_in = v.din;
    @(posedge clk);
    #1;
    i_ce    = 1'b0;
    i_clear = 1'b0;
    if (v.ce && !v.clr) begin
      exp_q.push_back({16'(cyc_n + 1), v.exp_t, v.exp_r});
    end
    check("o_full_trunc", int'(o_full_t), int'(v.exp_full));
    check("o_full_round", int'(o_full_r), int'(v.exp_full));
    repeat (v.gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: every o_ce must match the head of the expected queue.
  always @(negedge clk) begin
    if (o_ce_t || o_ce_r) begin
      if (exp_q.size() == 0) begin
        check("unexpected_o_ce", 1, 0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("o_ce_pair", int'({o_ce_t, o_ce_r}), 3);
        check("latency_cycle", cyc_n, int'(e[31:16]));
        check("data_trunc", int'(data_out_t), int'($signed(e[15:8])));
        check("data_round", int'(data_out_r), int'($signed(e[7:0])));
      end
    end
  end

  initial begin
    vec_t v;
    reset_n = 1'b0;
    i_ce    = 1'b0;
    i_clear = 1'b0;
    data_in = '0;

    // Step: 100 x4.
    add_v(1, 0, 100, 0,  25,  25, 0);
    add_v(1, 0, 100, 0,  50,  50, 0);
    add_v(1, 0, 100, 0,  75,  75, 0);
    add_v(1, 0, 100, 0, 100, 100, 1);
    add_v(0, 1, 0, 0, 0, 0, 0);
    // Rounding of small negatives.
    add_v(1, 0, -1, 0, -1,  0, 0);
    add_v(1, 0, -2, 0, -1, -1, 0);
    add_v(0, 1, 0, 0, 0, 0, 0);
    // Extremes.
    add_v(1, 0,  127, 0,   31,   32, 0);
    add_v(1, 0,  127, 0,   63,   64, 0);
    add_v(1, 0,  127, 0,   95,   95, 0);
    add_v(1, 0,  127, 0,  127,  127, 1);
    add_v(1, 0, -128, 0,   63,   63, 1);
    add_v(1, 0, -128, 0,   -1,    0, 1);
    add_v(1, 0, -128, 0,  -65,  -64, 1);
    add_v(1, 0, -128, 0, -128, -128, 1);
    add_v(0, 1, 0, 0, 0, 0, 0);
    // Sliding window.
    add_v(1, 0,  4, 0,  1,  1, 0);
    add_v(1, 0,  8, 0,  3,  3, 0);
    add_v(1, 0, 12, 0,  6,  6, 0);
    add_v(1, 0, 16, 0, 10, 10, 1);
    add_v(1, 0, 20, 0, 14, 14, 1);
    add_v(1, 0, 24, 0, 18, 18, 1);
    add_v(0, 1, 0, 0, 0, 0, 0);
    // Strobe every third cycle, then clear with a coincident sample.
    add_v(1, 0,  4, 2,  1,  1, 0);
    add_v(1, 0,  8, 2,  3,  3, 0);
    add_v(1, 0, 12, 2,  6,  6, 0);
    add_v(1, 1, 99, 2,  0,  0, 0);
    add_v(1, 0, 40, 2, 10, 10, 0);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_data_trunc", int'(data_out_t), 0);
    check("reset_data_round", int'(data_out_r), 0);
    check("reset_o_ce", int'({o_ce_t, o_ce_r}), 0);
    check("reset_o_full", int'({o_full_t, o_full_r}), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) drive(vecs[i]);

    // Clear alone: data_out must hold the last result.
    v = '{ce: 1'b0, clr: 1'b1, din: 8'sd0, gap: 3, exp_t: 8'sd0, exp_r: 8'sd0, exp_full: 1'b0};
    drive(v);
    check("hold_after_clear_trunc", int'(data_out_t), 10);
    check("hold_after_clear_round", int'(data_out_r), 10);
    check("queue_empty_before_reset", exp_q.size(), 0);

    // Reset while a sample sits in stage 1: its o_ce is suppressed.
    i_ce    = 1'b1;
    data_in = 8'sd50;
    @(posedge clk);
    #1;
    i_ce    = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("midreset_o_ce", int'({o_ce_t, o_ce_r}), 0);
    check("midreset_data_trunc", int'(data_out_t), 0);
    check("midreset_data_round", int'(data_out_r), 0);
    check("midreset_o_full", int'({o_full_t, o_full_r}), 0);
    @(posedge clk);
    #1;
    check("midreset_no_late_o_ce", int'({o_ce_t, o_ce_r}), 0);

    v = '{ce: 1'b1, clr: 1'b0, din: 8'sd8, gap: 0, exp_t: 8'sd2, exp_r: 8'sd2, exp_full: 1'b0};
    drive(v);
    v.exp_t = 8'sd4; v.exp_r = 8'sd4;
    drive(v);
    v.exp_t = 8'sd6; v.exp_r = 8'sd6;
    drive(v);
    v.exp_t = 8'sd8; v.exp_r = 8'sd8; v.exp_full = 1'b1;
    drive(v);

    // Bounded drain of outstanding results.
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    check("drain_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
